// File: rtl/rom_wb_arbiter.sv
// rom_wb_arbiter: two-master Wishbone read arbiter in front of a boot ROM.
// Round-robin grant on ties, at least one idle slave cycle between transfers,
// and a HOLD state that finishes a transfer abandoned by its master while
// hiding the late ack from it.
// Optional feature: define ROM_WB_ARB_TIMEOUT_EN to bound the wait for
// s_ack_i to TIMEOUT cycles. Expiry pulses the owner's err and frees the bus.
module rom_wb_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int ADR_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GNT0  = 3'd1,
        GNT1  = 3'd2,
        HOLD0 = 3'd3,
        HOLD1 = 3'd4
    } state_t;

    state_t           state_r;
    logic             last_gnt_r;
    logic [ADR_W-1:0] hold_adr_r;
    logic             req0_s;
    logic             req1_s;
    logic             expire_s;

    assign req0_s = m0_cyc_i & m0_stb_i;
    assign req1_s = m1_cyc_i & m1_stb_i;

`ifdef ROM_WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_cnt_r;

    // The counter never passes TIMEOUT-1: that value ends the transfer.
    assign expire_s = (state_r != IDLE) && (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

    // Wait counter: zero while idle, so every grant starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == IDLE) || s_ack_i || expire_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // Arbitration FSM: grant, abandon tracking, round-robin history, address freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b1;
            hold_adr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    // On a tie, m0 wins unless it owned the previous transfer.
                    if (req0_s && (!req1_s || last_gnt_r)) begin
                        state_r    <= GNT0;
                        hold_adr_r <= m0_adr_i;
                    end else if (req1_s) begin
                        state_r    <= GNT1;
                        hold_adr_r <= m1_adr_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT0: begin
                    if (s_ack_i || expire_s) begin
                        state_r    <= IDLE;
                        last_gnt_r <= 1'b0;
                    end else if (!m0_cyc_i) begin
                        state_r <= HOLD0;
                    end else begin
                        state_r <= GNT0;
                    end
                end
                GNT1: begin
                    if (s_ack_i || expire_s) begin
                        state_r    <= IDLE;
                        last_gnt_r <= 1'b1;
                    end else if (!m1_cyc_i) begin
                        state_r <= HOLD1;
                    end else begin
                        state_r <= GNT1;
                    end
                end
                HOLD0: begin
                    if (s_ack_i || expire_s) begin
                        state_r    <= IDLE;
                        last_gnt_r <= 1'b0;
                    end else begin
                        state_r <= HOLD0;
                    end
                end
                HOLD1: begin
                    if (s_ack_i || expire_s) begin
                        state_r    <= IDLE;
                        last_gnt_r <= 1'b1;
                    end else begin
                        state_r <= HOLD1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Bus routing: live address from the owner in GNT, frozen address in HOLD.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_adr_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_r)
            GNT0: begin
                s_cyc_o  = 1'b1;
                s_stb_o  = 1'b1;
                s_adr_o  = m0_adr_i;
                m0_ack_o = s_ack_i;
                m0_err_o = expire_s & ~s_ack_i;
            end
            GNT1: begin
                s_cyc_o  = 1'b1;
                s_stb_o  = 1'b1;
                s_adr_o  = m1_adr_i;
                m1_ack_o = s_ack_i;
                m1_err_o = expire_s & ~s_ack_i;
            end
            HOLD0, HOLD1: begin
                s_cyc_o = 1'b1;
                s_stb_o = 1'b1;
                s_adr_o = hold_adr_r;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: doc/rom_wb_arbiter.md
ROM_WB_ARBITER -- requirements
Module: rom_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the max cycles a granted transfer may wait for s_ack_i.
REQ-002 SHALL have parameter ADR_W, default 5, giving the word-address width shared by both masters and the slave.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have ports m0_adr_i / m1_adr_i, input, ADR_W, master word address.
REQ-006 SHALL have ports m0_cyc_i, m0_stb_i / m1_cyc_i, m1_stb_i, input, 1 each, Wishbone cycle and strobe.
REQ-007 SHALL have ports m0_dat_o / m1_dat_o, output, 32, read data.
REQ-008 SHALL have ports m0_ack_o, m0_err_o / m1_ack_o, m1_err_o, output, 1 each, termination.
REQ-009 SHALL have ports s_adr_o (output, ADR_W), s_cyc_o and s_stb_o (output, 1 each), s_dat_i (input, 32) and s_ack_i (input, 1), the slave side driving the boot ROM.

Function
REQ-010 SHALL define a master request as reqN = mN_cyc_i & mN_stb_i.
REQ-011 SHALL implement FSM states IDLE, GNT0, GNT1, HOLD0 and HOLD1, with GNT/HOLD held in registers.
REQ-012 From IDLE with exactly one request, SHALL move to that master's GNT state next cycle.
REQ-013 From IDLE with both requesting, SHALL grant the master other than last_gnt (round-robin); last_gnt resets to 1, so m0 wins the first tie.
REQ-014 In GNTn SHALL drive s_cyc_o = s_stb_o = 1 and s_adr_o = mn_adr_i, all combinational from the granted master.
REQ-015 In IDLE SHALL drive s_cyc_o = s_stb_o = 0 and s_adr_o = 0, guaranteeing at least one idle slave cycle between transfers.
REQ-016 mN_dat_o SHALL equal s_dat_i for both masters.
REQ-017 mn_ack_o SHALL be s_ack_i & (state == GNTn), combinational; the other master's ack SHALL stay 0.
REQ-018 On s_ack_i in GNTn, SHALL go to IDLE next cycle and set last_gnt = n.
REQ-019 If mn_cyc_i drops in GNTn before ack, SHALL go to HOLDn, keep s_cyc_o/s_stb_o = 1 and s_adr_o frozen at the address registered at grant, and suppress mn_ack_o.
REQ-020 On s_ack_i in HOLDn, SHALL go to IDLE with last_gnt = n.
REQ-021 A new request from the same master during HOLDn SHALL wait for IDLE.
REQ-022 The grant SHALL never change while s_cyc_o = 1, except on timeout (REQ-028).

Reset
REQ-023 On rst SHALL immediately set state = IDLE, last_gnt = 1 and the timeout counter = 0.
REQ-024 On rst SHALL force s_cyc_o, s_stb_o, mN_ack_o and mN_err_o to 0 and s_adr_o to 0, including when reset arrives mid-transfer.

Configuration
REQ-025 The timeout feature SHALL be compiled in only when macro ROM_WB_ARB_TIMEOUT_EN is defined.
REQ-026 With the macro defined, a counter SHALL clear on entry to GNT/HOLD and increment each cycle without s_ack_i.
REQ-027 A counter of ceil(log2(TIMEOUT)) bits SHALL suffice, with no wrap before expiry.
REQ-028 When the counter reaches TIMEOUT-1 without ack, SHALL pulse mn_err_o for 1 cycle (in GNTn only), go to IDLE and set last_gnt = n.
REQ-029 If s_ack_i and expiry coincide, ack SHALL win and err SHALL stay 0.
REQ-030 Without the macro, mN_err_o SHALL be constant 0, no counter SHALL exist, and GNT/HOLD SHALL wait indefinitely.

Verification
REQ-031 Bench SHALL check: m0 reads adr 5'h03, slave acks after 17 cycles -> s_adr_o = 3 from the cycle after request, m0_ack_o exactly 1 cycle, m0_dat_o = s_dat_i, then s_cyc_o = 0 for at least 1 cycle.
REQ-032 Bench SHALL check: both masters request continuously from reset -> grants alternate m0, m1, m0, m1; no ack is ever routed to the non-granted master.
REQ-033 Bench SHALL check: m1 drops cyc 4 cycles into its grant -> HOLD1, s_cyc_o stays 1, s_ack_i arrives with m1_ack_o = 0, then m0's pending request is granted.
REQ-034 Bench SHALL check: rst asserted mid-GNT0 -> s_cyc_o and m0_ack_o fall in the same cycle; after release, m0 wins a simultaneous request.
REQ-035 Bench SHALL check, with ROM_WB_ARB_TIMEOUT_EN and TIMEOUT = 8: slave never acks -> m0_err_o pulses in the 8th granted cycle, then IDLE; ack on that same cycle -> ack only, err = 0.
